// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch buffer.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries; flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  assign o_count = r_count;
  assign o_head  = r_count != '0 ? r_mem[r_rd] : '0;
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction prefetch into a small FIFO,
// one outstanding memory request, redirect flush with squashed-response drain.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  input  logic        fetch_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  state_t        r_state, w_state_nxt;
  logic [31:0]   r_addr, r_next_pc, w_pc_nxt;
  logic [CW-1:0] w_count, w_count_nxt;
  logic          w_ack, w_free, w_push, w_pop, w_issue;
  fetch_entry_t  w_head, w_entry;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // A live request that is neither acked nor redirected keeps waiting; a
  // redirected one must still be drained before a new address can go out.
  always_comb
    w_state_nxt = !w_free ? (r_state == REQ && !redirect_valid ? REQ : DRAIN)
                          : (w_issue ? REQ : IDLE);
  always_comb begin
    w_ack       = mem_ack && r_state != IDLE;
    w_free      = r_state == IDLE || w_ack;
    w_pop       = fetch_valid && fetch_ready && !redirect_valid;
    w_push      = r_state == REQ && w_ack && !redirect_valid;
    w_count_nxt = redirect_valid ? '0 : w_count + CW'(w_push) - CW'(w_pop);
    w_pc_nxt    = redirect_valid ? redirect_pc & ~32'd3 : w_push ? r_addr + 32'd4 : r_next_pc;
    w_issue     = w_free && w_count_nxt < CW'(DEPTH);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr    <= RESET_PC;
      r_next_pc <= RESET_PC;
    end else begin
      r_next_pc <= w_pc_nxt;
      if (w_issue) r_addr <= w_pc_nxt;
    end
  assign w_entry = '{pc: r_addr, instr: mem_rdata};
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );
  assign fetch_valid = w_count != '0;
  assign fetch_pc    = w_head.pc;
  assign fetch_instr = w_head.instr;
  assign mem_req     = r_state != IDLE;
  assign mem_addr    = r_addr;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed checks of prefetch, backpressure, redirect,
// address wrap and asynchronous reset against a modelled instruction memory.
module tb_instr_prefetch_buffer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        redirect_valid = 1'b0, fetch_ready = 1'b0, mem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, mem_rdata = '0;
  logic        fetch_valid, mem_req;
  logic [31:0] fetch_pc, fetch_instr, mem_addr;
  int          total = 0, bad = 0, mode = 1, lat = 0;
  logic        man_ack = 1'b0, found;
  logic [31:0] man_data = '0;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .fetch_ready    (fetch_ready),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: mode 0 manual, mode 1 zero-wait, mode 2 ack on third cycle of request.
  always @(negedge clk) begin
    if (mode == 0) begin
      mem_ack   = man_ack;
      mem_rdata = man_data;
    end else begin
      mem_rdata = word(mem_addr);
      if (!mem_req) begin
        mem_ack = 1'b0;
        lat     = 0;
      end else if (mode == 1) mem_ack = 1'b1;
      else if (lat == 2) begin
        mem_ack = 1'b1;
        lat     = 0;
      end else begin
        mem_ack = 1'b0;
        lat++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic restart();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      found = mem_req && mem_addr == a;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    mode = 1;
    fetch_ready = 1'b1;
    repeat (3) tick();
    chk("rst req", 32'(mem_req), 0);
    chk("rst addr", mem_addr, 32'h0);
    chk("rst valid", 32'(fetch_valid), 0);
    chk("rst pc", fetch_pc, 32'h0);
    chk("rst instr", fetch_instr, 32'h0);
    rst = 1'b0;
    tick();
    chk("t1 req", 32'(mem_req), 1);
    chk("t1 addr0", mem_addr, 32'h0);
    chk("t1 valid0", 32'(fetch_valid), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t1 addr", mem_addr, 4 * (k + 1));
      chk("t1 valid", 32'(fetch_valid), 1);
      chk("t1 pc", fetch_pc, 4 * k);
      chk("t1 instr", fetch_instr, word(4 * k));
    end

    fetch_ready = 1'b0;
    restart();
    repeat (5) tick();
    chk("t2 full req", 32'(mem_req), 0);
    chk("t2 full valid", 32'(fetch_valid), 1);
    chk("t2 full pc", fetch_pc, 32'h0);
    repeat (3) tick();
    chk("t2 hold req", 32'(mem_req), 0);
    chk("t2 hold pc", fetch_pc, 32'h0);
    fetch_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2 req", 32'(mem_req), 1);
      chk("t2 addr", mem_addr, 16 + 4 * k);
      chk("t2 pc", fetch_pc, 4 + 4 * k);
    end

    mode = 2;
    restart();
    wait_addr(32'h8);
    chk("t3 reach8", 32'(found), 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3 flush valid", 32'(fetch_valid), 0);
    chk("t3 drain req", 32'(mem_req), 1);
    chk("t3 drain addr", mem_addr, 32'h8);
    tick();
    chk("t3 drain2 addr", mem_addr, 32'h8);
    chk("t3 drain2 valid", 32'(fetch_valid), 0);
    tick();
    chk("t3 new addr", mem_addr, 32'h100);
    chk("t3 new valid", 32'(fetch_valid), 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = fetch_valid;
    end
    chk("t3 got", 32'(found), 1);
    chk("t3 pc", fetch_pc, 32'h100);
    chk("t3 instr", fetch_instr, word(32'h100));

    mode = 1;
    repeat (4) tick();
    chk("t4 pre valid", 32'(fetch_valid), 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("t4 valid", 32'(fetch_valid), 0);
    chk("t4 pc", fetch_pc, 32'h0);
    chk("t4 req", 32'(mem_req), 1);
    chk("t4 addr", mem_addr, 32'h200);
    tick();
    chk("t4 valid2", 32'(fetch_valid), 1);
    chk("t4 pc2", fetch_pc, 32'h200);
    chk("t4 instr2", fetch_instr, word(32'h200));
    chk("t4 addr2", mem_addr, 32'h204);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    chk("t5 addr", mem_addr, 32'hFFFF_FFF8);
    chk("t5 valid", 32'(fetch_valid), 0);
    tick();
    chk("t5 pc0", fetch_pc, 32'hFFFF_FFF8);
    chk("t5 addr1", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5 pc1", fetch_pc, 32'hFFFF_FFFC);
    chk("t5 addr2", mem_addr, 32'h0);
    tick();
    chk("t5 pc2", fetch_pc, 32'h0);
    chk("t5 instr2", fetch_instr, word(32'h0));
    chk("t5 addr3", mem_addr, 32'h4);

    mode = 2;
    fetch_ready = 1'b0;
    restart();
    wait_addr(32'h8);
    chk("t6 reach8", 32'(found), 1);
    chk("t6 valid", 32'(fetch_valid), 1);
    chk("t6 pc", fetch_pc, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst req", 32'(mem_req), 0);
    chk("t6 rst addr", mem_addr, 32'h0);
    chk("t6 rst valid", 32'(fetch_valid), 0);
    chk("t6 rst pc", fetch_pc, 32'h0);
    chk("t6 rst instr", fetch_instr, 32'h0);
    mode = 0;
    man_ack = 1'b1;
    man_data = 32'hDEAD_BEEF;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t6 restart req", 32'(mem_req), 1);
    chk("t6 restart addr", mem_addr, 32'h0);
    chk("t6 stray ack", 32'(fetch_valid), 0);
    man_ack = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Instruction prefetch buffer between the CPU fetch port and a variable-latency instruction memory. It issues sequential word fetches ahead of the CPU into a small FIFO of {pc, instr} entries. It hands them to the CPU with a valid/ready handshake and flushes on redirect (taken branch, jal, jalr). Only one memory request is outstanding at any time; responses to squashed requests are drained and discarded.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  single-cycle flush-and-restart request from CPU.
- redirect_pc  in  32  restart address; bits [1:0] forced to 0.
- fetch_valid  out  1  head entry available.
- fetch_pc  out  32  PC of head entry.
- fetch_instr  out  32  instruction word of head entry.
- fetch_ready  in  1  CPU consumes head when fetch_valid && fetch_ready.
- mem_req  out  1  request to instruction memory; held until acked.
- mem_addr  out  32  word address of request; stable while mem_req high.
- mem_ack  in  1  response strobe; valid only while mem_req high, may arrive in same cycle as request.
- mem_rdata  in  32  instruction word, valid with mem_ack.

## Operation
- States: IDLE (no request outstanding), REQ (live request outstanding), DRAIN (outstanding request squashed by redirect).
- IDLE: if slot free (count_next < DEPTH), drive mem_req=1, mem_addr=next_pc, go REQ; else stay IDLE.
- REQ, mem_ack=1, no redirect: push {mem_addr, mem_rdata}; next_pc = mem_addr+4. If count_next+1 ≤ DEPTH (count_next includes this push and any pop), keep mem_req=1 with the new address (back-to-back), else mem_req=0 → IDLE.
- REQ, redirect_valid (with or without mem_ack): flush FIFO; next_pc = {redirect_pc[31:2],2'b00}. With mem_ack: data discarded; the new request is issued next cycle → REQ. Without mem_ack: → DRAIN, keeping mem_req/mem_addr unchanged.
- DRAIN, mem_ack: discard data, issue request at next_pc → REQ. Redirect in DRAIN: update next_pc only, stay DRAIN.
- IDLE, redirect: flush, update next_pc, issue at new address next cycle.
- Redirect concurrent with pop: redirect wins; the pop is a no-op on the flushed FIFO.
- Pop and push in the same cycle: both occur; count unchanged.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- fetch_pc/fetch_instr = head entry when fetch_valid, else 0.
- Reset (any time, including mid-request): state IDLE, FIFO empty, next_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, fetch_valid=0, fetch_pc=0, fetch_instr=0. Any ack arriving after reset release while mem_req=0 is ignored.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- First mem_req: first rising edge after rst deasserts.
- Push latency: ack sampled at edge N → fetch_valid=1 after edge N.
- Redirect sampled at edge N → fetch_valid=0 after edge N. New mem_req after edge N if no live request or the ack arrives at N; otherwise one cycle after the draining ack.
- Throughput: one instruction per cycle with a 0-wait memory (ack in the cycle of request) and fetch_ready held high.
- FIFO never overflows: a slot is reserved for each outstanding request.

## Structure
- Package fetch_pkg: state enum {IDLE, REQ, DRAIN}, struct fetch_entry_t {pc[31:0], instr[31:0]}, constant RESET_PC_DEFAULT.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head outputs. Flush has priority over push/pop.
- Top level: FSM, next_pc counter, slot accounting.

## Test plan
- Reset release, 0-wait memory, fetch_ready=1 → mem_addr 0,4,8,… on consecutive cycles; fetch_pc follows one cycle later; no gaps.
- fetch_ready=0, DEPTH=4 → exactly 4 entries (pc 0..12) buffered, then mem_req=0. Raising fetch_ready restarts requests at 16 with no loss or duplicate.
- 3-cycle memory latency, redirect to 0x100 while request at 0x8 is pending → 0x8 data discarded; the next mem_addr is 0x100; fetch_pc is never 0x8.
- Redirect to 0x203 in the same cycle as mem_ack and a pop → FIFO empty next cycle; mem_addr=0x200; the acked word is never delivered.
- Redirect to 0xFFFF_FFF8 → fetch_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-REQ with 2 entries buffered → outputs at reset values immediately; after release, fetch restarts at RESET_PC.
